control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Hardwired T-state controller for the 32-bit datapath: fetches, decodes and executes one instruction
//  at a time by driving bus-source select, register-in strobes, ALU op and memory handshake.
//  Sits between IR/CON FF outputs of the datapath and every control input of the datapath and memory.
// PARAMETERS
//  OPC_W     5   opcode width, IR[31:27]
//  SEL_W     5   bus-source select width, same code space as the bus multiplexer select
//  ALUOP_W   5   ALU operation code width
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-high
//  stop       in   1        level; halts sequencing at the next instruction boundary
//  ir         in   32       IR contents; opcode = ir[31:27]
//  con_ff     in   1        branch-condition flag from the CON FF
//  mem_ready  in   1        memory completes the current read/write this cycle
//  bus_sel    out  SEL_W    bus source code: R0..R15=0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, C=23
//  gra,grb,grc out 1 each   register-field select for the select/encode logic
//  r_in       out  1        write selected Ra
//  ba_out     out  1        base-address drive (R0 reads as 0)
//  pc_in,pc_inc,ir_in,y_in,z_in,mar_in,mdr_in,hi_in,lo_in,con_in,out_in  out 1 each  register load strobes
//  mdr_read   out  1        MDR mux selects memory (1) or bus (0)
//  mem_read, mem_write out 1  memory request; held until mem_ready
//  alu_op     out  ALUOP_W  ALU function, valid while z_in=1
//  run        out  1        1 while fetching/executing
//  illegal_op out  1        one-cycle pulse on an undefined opcode
// BEHAVIOUR
//  - Reset: state=T0, all strobes 0, bus_sel=0, alu_op=ADD, run=1, illegal_op=0. Mid-instruction reset aborts
//    and drops mem_read/mem_write in that cycle. Moore outputs: all outputs decoded from the registered state.
//  - T0: stop=1 -> IDLE (run=0), else bus_sel=PC, mar_in, pc_inc. IDLE -> T0 when stop=0.
//  - T1: mem_read, mdr_read, mdr_in; stay in T1 until mem_ready=1. T2: bus_sel=MDR, ir_in. T3.. execute.
//  - ALU reg (add,sub,and,or,shr,shl,ror,rol): T3 grb,Rout,y_in; T4 grc,Rout,alu_op,z_in; T5 ZLO,gra,r_in -> T0.
//  - neg/not: T3 grb,Rout,alu_op,z_in; T4 ZLO,gra,r_in. Immediate (addi,andi,ori): as ALU reg, T4 uses C not grc.
//  - mul/div: T3 gra,Rout,y_in; T4 grb,Rout,z_in; T5 ZLO,lo_in; T6 ZHI,hi_in.
//  - ld/ldi: T3 grb,ba_out,y_in; T4 C,ADD,z_in; T5 ZLO -> ldi: gra,r_in,done | ld: mar_in;
//    ld T6 mem_read,mdr_read,mdr_in wait mem_ready; T7 MDR,gra,r_in.
//  - st: T3-T5 as ld; T6 gra,Rout,mdr_in(mdr_read=0); T7 mem_write wait mem_ready.
//  - br: T3 gra,Rout,con_in; T4 PC,y_in; T5 C,ADD,z_in; T6 if con_ff: ZLO,pc_in; else no strobe.
//  - jr: T3 gra,Rout,pc_in. mfhi/mflo: T3 HI/LO,gra,r_in. in: T3 INPORT,gra,r_in. out: T3 gra,Rout,out_in.
//  - nop: T3 no strobe. halt: enter HALT, run=0, exit only by reset.
//  - Undefined opcode: illegal_op pulse in T3, treated as nop.
//  - Exactly one bus driver per cycle; at most one of mem_read/mem_write; strobes never set during wait cycles except the request itself.
//  - Instruction ends -> T0 next cycle; stop sampled only in T0.
// CONFIGURATION
//  SINGLE_STEP_EN defined: extra input step (1b); in all states except T1/T6/T7 memory waits, the FSM advances
//  only in a cycle with step=1, and strobes are gated to that cycle only; run=0 while waiting for step.
//  Undefined: free-running, one state per clock; no step port.
// STRUCTURE
//  cpu_ctrl_pkg: opcode localparams, state encoding, BUS_SEL_* codes, ALU_* codes.
//  Sub-module opcode_decoder: ir[31:27] -> instruction class one-hot + alu_op + illegal flag (combinational).
//  control_sequencer holds the state register and the state->strobe decode.
// TESTING
//  1 reset mid-T1 with mem_read=1 -> next cycle mem_read=0, state T0, bus_sel=PC, mar_in=1.
//  2 add (opc 00011), mem_ready immediate -> T0..T5 in 6 cycles; T4 alu_op=ADD,z_in; T5 bus_sel=19,gra,r_in.
//  3 ld with mem_ready delayed 3 cycles in T6 -> mem_read held 4 cycles, r_in only in T7 with bus_sel=21.
//  4 br with con_ff=0 -> no pc_in; with con_ff=1 -> pc_in in T6 with bus_sel=19.
//  5 stop=1 during execute -> instruction completes, IDLE with run=0; stop=0 -> T0 next cycle; halt -> run=0 until reset.
//  6 opcode 11111 -> illegal_op pulse 1 cycle in T3, no register strobe, back to T0.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, bus-source codes, ALU codes and state encoding for the
// hardwired T-state controller.
package control_sequencer_pkg;

   localparam int OPC_W   = 5;
   localparam int SEL_W   = 5;
   localparam int ALUOP_W = 5;

   localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000, OPC_LDI  = 5'b00001, OPC_ST   = 5'b00010;
   localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011, OPC_SUB  = 5'b00100, OPC_AND  = 5'b00101;
   localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110, OPC_SHR  = 5'b00111, OPC_SHL  = 5'b01000;
   localparam logic [OPC_W-1:0] OPC_ROR  = 5'b01001, OPC_ROL  = 5'b01010, OPC_ADDI = 5'b01011;
   localparam logic [OPC_W-1:0] OPC_ANDI = 5'b01100, OPC_ORI  = 5'b01101, OPC_MUL  = 5'b01110;
   localparam logic [OPC_W-1:0] OPC_DIV  = 5'b01111, OPC_NEG  = 5'b10000, OPC_NOT  = 5'b10001;
   localparam logic [OPC_W-1:0] OPC_BR   = 5'b10010, OPC_JR   = 5'b10011, OPC_IN   = 5'b10100;
   localparam logic [OPC_W-1:0] OPC_OUT  = 5'b10101, OPC_MFHI = 5'b10110, OPC_MFLO = 5'b10111;
   localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11000, OPC_HALT = 5'b11001;

   localparam logic [SEL_W-1:0] BUS_SEL_HI  = 5'd16, BUS_SEL_LO  = 5'd17, BUS_SEL_ZHI    = 5'd18;
   localparam logic [SEL_W-1:0] BUS_SEL_ZLO = 5'd19, BUS_SEL_PC  = 5'd20, BUS_SEL_MDR    = 5'd21;
   localparam logic [SEL_W-1:0] BUS_SEL_INPORT = 5'd22, BUS_SEL_C = 5'd23;

   localparam logic [ALUOP_W-1:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2,  ALU_OR  = 5'd3;
   localparam logic [ALUOP_W-1:0] ALU_SHR = 5'd4, ALU_SHL = 5'd5, ALU_ROR = 5'd6,  ALU_ROL = 5'd7;
   localparam logic [ALUOP_W-1:0] ALU_MUL = 5'd8, ALU_DIV = 5'd9, ALU_NEG = 5'd10, ALU_NOT = 5'd11;

   typedef enum logic [3:0] {
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_IDLE, ST_HALT
   } state_t;

   typedef struct packed {
      logic alu_reg;
      logic alu_imm;
      logic neg_not;
      logic mul_div;
      logic ld;
      logic ldi;
      logic st;
      logic br;
      logic jr;
      logic mfhi;
      logic mflo;
      logic inp;
      logic outp;
      logic nop;
      logic halt;
   } instr_class_t;

   // Register fields are 4 bits; R0..R15 occupy the low half of the bus-select space.
   function automatic logic [SEL_W-1:0] reg_sel(input logic [3:0] r);
      return {1'b0, r};
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath/memory control bundle between the sequencer (master) and the
// datapath (slave); step exists only when SINGLE_STEP_EN is defined.
interface control_sequencer_if;
   import control_sequencer_pkg::*;

`ifdef SINGLE_STEP_EN
   logic                step;
`endif
   logic                stop;
   logic [31:0]         ir;
   logic                con_ff;
   logic                mem_ready;
   logic [SEL_W-1:0]    bus_sel;
   logic                gra, grb, grc;
   logic                r_in, ba_out;
   logic                pc_in, pc_inc, ir_in, y_in, z_in, mar_in, mdr_in;
   logic                hi_in, lo_in, con_in, out_in;
   logic                mdr_read, mem_read, mem_write;
   logic [ALUOP_W-1:0]  alu_op;
   logic                run;
   logic                illegal_op;
   state_t              state;

   modport master (
`ifdef SINGLE_STEP_EN
      input  step,
`endif
      input  stop, ir, con_ff, mem_ready,
      output bus_sel, gra, grb, grc, r_in, ba_out,
      output pc_in, pc_inc, ir_in, y_in, z_in, mar_in, mdr_in,
      output hi_in, lo_in, con_in, out_in,
      output mdr_read, mem_read, mem_write, alu_op, run, illegal_op, state
   );

   modport slave (
`ifdef SINGLE_STEP_EN
      output step,
`endif
      output stop, ir, con_ff, mem_ready,
      input  bus_sel, gra, grb, grc, r_in, ba_out,
      input  pc_in, pc_inc, ir_in, y_in, z_in, mar_in, mdr_in,
      input  hi_in, lo_in, con_in, out_in,
      input  mdr_read, mem_read, mem_write, alu_op, run, illegal_op, state
   );

endinterface

// File: rtl/control_sequencer_decoder.sv
// Combinational opcode decode: instruction class one-hot, ALU function and
// illegal-opcode flag.
module control_sequencer_decoder
   import control_sequencer_pkg::*;
(
   input  logic [OPC_W-1:0]   i_opcode,
   output instr_class_t       o_class,
   output logic [ALUOP_W-1:0] o_alu_op,
   output logic               o_illegal
);

   always_comb begin
      o_class   = '0;
      o_alu_op  = ALU_ADD;
      o_illegal = 1'b0;
      case (i_opcode)
         OPC_LD:   o_class.ld  = 1'b1;
         OPC_LDI:  o_class.ldi = 1'b1;
         OPC_ST:   o_class.st  = 1'b1;
         OPC_ADD:  begin o_class.alu_reg = 1'b1; o_alu_op = ALU_ADD; end
         OPC_SUB:  begin o_class.alu_reg = 1'b1; o_alu_op = ALU_SUB; end
         OPC_AND:  begin o_class.alu_reg = 1'b1; o_alu_op = ALU_AND; end
         OPC_OR:   begin o_class.alu_reg = 1'b1; o_alu_op = ALU_OR;  end
         OPC_SHR:  begin o_class.alu_reg = 1'b1; o_alu_op = ALU_SHR; end
         OPC_SHL:  begin o_class.alu_reg = 1'b1; o_alu_op = ALU_SHL; end
         OPC_ROR:  begin o_class.alu_reg = 1'b1; o_alu_op = ALU_ROR; end
         OPC_ROL:  begin o_class.alu_reg = 1'b1; o_alu_op = ALU_ROL; end
         OPC_ADDI: begin o_class.alu_imm = 1'b1; o_alu_op = ALU_ADD; end
         OPC_ANDI: begin o_class.alu_imm = 1'b1; o_alu_op = ALU_AND; end
         OPC_ORI:  begin o_class.alu_imm = 1'b1; o_alu_op = ALU_OR;  end
         OPC_MUL:  begin o_class.mul_div = 1'b1; o_alu_op = ALU_MUL; end
         OPC_DIV:  begin o_class.mul_div = 1'b1; o_alu_op = ALU_DIV; end
         OPC_NEG:  begin o_class.neg_not = 1'b1; o_alu_op = ALU_NEG; end
         OPC_NOT:  begin o_class.neg_not = 1'b1; o_alu_op = ALU_NOT; end
         OPC_BR:   o_class.br   = 1'b1;
         OPC_JR:   o_class.jr   = 1'b1;
         OPC_IN:   o_class.inp  = 1'b1;
         OPC_OUT:  o_class.outp = 1'b1;
         OPC_MFHI: o_class.mfhi = 1'b1;
         OPC_MFLO: o_class.mflo = 1'b1;
         OPC_NOP:  o_class.nop  = 1'b1;
         OPC_HALT: o_class.halt = 1'b1;
         default:  o_illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state controller: state register plus state->strobe decode.
// Optional SINGLE_STEP_EN: non-memory states advance only on step=1.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input logic                  clk,
   input logic                  reset,
   control_sequencer_if.master  cs
);

   state_t             r_state;
   instr_class_t       w_cls;
   logic [ALUOP_W-1:0] w_alu_op;
   logic               w_illegal;
   logic [3:0]         w_ra, w_rb, w_rc;
   logic               w_unused_ir;
   logic               w_step, w_wait, w_adv;

   assign w_ra        = cs.ir[26:23];
   assign w_rb        = cs.ir[22:19];
   assign w_rc        = cs.ir[18:15];
   assign w_unused_ir = ^cs.ir[14:0];
   assign cs.state    = r_state;

   control_sequencer_decoder u_decoder (
      .i_opcode  (cs.ir[31:27]),
      .o_class   (w_cls),
      .o_alu_op  (w_alu_op),
      .o_illegal (w_illegal)
   );

`ifdef SINGLE_STEP_EN
   assign w_step = cs.step;
`else
   assign w_step = 1'b1;
`endif

   // Memory waits always run free so the request is held until mem_ready.
   assign w_wait = (r_state == ST_T1) || (r_state == ST_T6 && w_cls.ld) ||
                   (r_state == ST_T7 && w_cls.st);
   assign w_adv  = w_step || w_wait;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_T0;
      end else if (w_adv) begin
         case (r_state)
            ST_T0:   r_state <= cs.stop ? ST_IDLE : ST_T1;
            ST_IDLE: if (!cs.stop) r_state <= ST_T0;
            ST_T1:   if (cs.mem_ready) r_state <= ST_T2;
            ST_T2:   r_state <= ST_T3;
            ST_T3: begin
               if (w_cls.halt)
                  r_state <= ST_HALT;
               else if (w_cls.alu_reg || w_cls.alu_imm || w_cls.neg_not || w_cls.mul_div ||
                        w_cls.ld || w_cls.ldi || w_cls.st || w_cls.br)
                  r_state <= ST_T4;
               else
                  r_state <= ST_T0;
            end
            ST_T4:   r_state <= w_cls.neg_not ? ST_T0 : ST_T5;
            ST_T5:   r_state <= (w_cls.mul_div || w_cls.ld || w_cls.st || w_cls.br) ? ST_T6 : ST_T0;
            ST_T6: begin
               if (w_cls.ld) begin
                  if (cs.mem_ready) r_state <= ST_T7;
               end else if (w_cls.st) begin
                  r_state <= ST_T7;
               end else begin
                  r_state <= ST_T0;
               end
            end
            ST_T7:   if (!w_cls.st || cs.mem_ready) r_state <= ST_T0;
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_T0;
         endcase
      end
   end

   always_comb begin
      cs.bus_sel = '0;     cs.gra = 1'b0;       cs.grb = 1'b0;        cs.grc = 1'b0;
      cs.r_in = 1'b0;      cs.ba_out = 1'b0;    cs.pc_in = 1'b0;      cs.pc_inc = 1'b0;
      cs.ir_in = 1'b0;     cs.y_in = 1'b0;      cs.z_in = 1'b0;       cs.mar_in = 1'b0;
      cs.mdr_in = 1'b0;    cs.hi_in = 1'b0;     cs.lo_in = 1'b0;      cs.con_in = 1'b0;
      cs.out_in = 1'b0;    cs.mdr_read = 1'b0;  cs.mem_read = 1'b0;   cs.mem_write = 1'b0;
      cs.alu_op = ALU_ADD; cs.run = 1'b1;       cs.illegal_op = 1'b0;
      if (!w_adv) begin
         cs.run = 1'b0;
      end else begin
         case (r_state)
            ST_T0: if (!cs.stop) begin
               cs.bus_sel = BUS_SEL_PC; cs.mar_in = 1'b1; cs.pc_inc = 1'b1;
            end
            ST_T1: begin
               cs.mem_read = 1'b1; cs.mdr_read = 1'b1; cs.mdr_in = cs.mem_ready;
            end
            ST_T2: begin
               cs.bus_sel = BUS_SEL_MDR; cs.ir_in = 1'b1;
            end
            ST_T3: begin
               if (w_cls.alu_reg || w_cls.alu_imm) begin
                  cs.grb = 1'b1; cs.bus_sel = reg_sel(w_rb); cs.y_in = 1'b1;
               end else if (w_cls.neg_not) begin
                  cs.grb = 1'b1; cs.bus_sel = reg_sel(w_rb); cs.alu_op = w_alu_op; cs.z_in = 1'b1;
               end else if (w_cls.mul_div) begin
                  cs.gra = 1'b1; cs.bus_sel = reg_sel(w_ra); cs.y_in = 1'b1;
               end else if (w_cls.ld || w_cls.ldi || w_cls.st) begin
                  cs.grb = 1'b1; cs.bus_sel = reg_sel(w_rb); cs.ba_out = 1'b1; cs.y_in = 1'b1;
               end else if (w_cls.br) begin
                  cs.gra = 1'b1; cs.bus_sel = reg_sel(w_ra); cs.con_in = 1'b1;
               end else if (w_cls.jr) begin
                  cs.gra = 1'b1; cs.bus_sel = reg_sel(w_ra); cs.pc_in = 1'b1;
               end else if (w_cls.mfhi) begin
                  cs.bus_sel = BUS_SEL_HI; cs.gra = 1'b1; cs.r_in = 1'b1;
               end else if (w_cls.mflo) begin
                  cs.bus_sel = BUS_SEL_LO; cs.gra = 1'b1; cs.r_in = 1'b1;
               end else if (w_cls.inp) begin
                  cs.bus_sel = BUS_SEL_INPORT; cs.gra = 1'b1; cs.r_in = 1'b1;
               end else if (w_cls.outp) begin
                  cs.gra = 1'b1; cs.bus_sel = reg_sel(w_ra); cs.out_in = 1'b1;
               end else if (w_illegal) begin
                  cs.illegal_op = 1'b1;
               end
            end
            ST_T4: begin
               if (w_cls.alu_reg) begin
                  cs.grc = 1'b1; cs.bus_sel = reg_sel(w_rc); cs.alu_op = w_alu_op; cs.z_in = 1'b1;
               end else if (w_cls.alu_imm) begin
                  cs.bus_sel = BUS_SEL_C; cs.alu_op = w_alu_op; cs.z_in = 1'b1;
               end else if (w_cls.neg_not) begin
                  cs.bus_sel = BUS_SEL_ZLO; cs.gra = 1'b1; cs.r_in = 1'b1;
               end else if (w_cls.mul_div) begin
                  cs.grb = 1'b1; cs.bus_sel = reg_sel(w_rb); cs.alu_op = w_alu_op; cs.z_in = 1'b1;
               end else if (w_cls.ld || w_cls.ldi || w_cls.st) begin
                  cs.bus_sel = BUS_SEL_C; cs.alu_op = ALU_ADD; cs.z_in = 1'b1;
               end else if (w_cls.br) begin
                  cs.bus_sel = BUS_SEL_PC; cs.y_in = 1'b1;
               end
            end
            ST_T5: begin
               if (w_cls.alu_reg || w_cls.alu_imm || w_cls.ldi) begin
                  cs.bus_sel = BUS_SEL_ZLO; cs.gra = 1'b1; cs.r_in = 1'b1;
               end else if (w_cls.mul_div) begin
                  cs.bus_sel = BUS_SEL_ZLO; cs.lo_in = 1'b1;
               end else if (w_cls.ld || w_cls.st) begin
                  cs.bus_sel = BUS_SEL_ZLO; cs.mar_in = 1'b1;
               end else if (w_cls.br) begin
                  cs.bus_sel = BUS_SEL_C; cs.alu_op = ALU_ADD; cs.z_in = 1'b1;
               end
            end
            ST_T6: begin
               if (w_cls.mul_div) begin
                  cs.bus_sel = BUS_SEL_ZHI; cs.hi_in = 1'b1;
               end else if (w_cls.ld) begin
                  cs.mem_read = 1'b1; cs.mdr_read = 1'b1; cs.mdr_in = cs.mem_ready;
               end else if (w_cls.st) begin
                  cs.gra = 1'b1; cs.bus_sel = reg_sel(w_ra); cs.mdr_in = 1'b1;
               end else if (w_cls.br && cs.con_ff) begin
                  cs.bus_sel = BUS_SEL_ZLO; cs.pc_in = 1'b1;
               end
            end
            ST_T7: begin
               if (w_cls.ld) begin
                  cs.bus_sel = BUS_SEL_MDR; cs.gra = 1'b1; cs.r_in = 1'b1;
               end else if (w_cls.st) begin
                  cs.mem_write = 1'b1;
               end
            end
            ST_IDLE, ST_HALT: cs.run = 1'b0;
            default: ;
         endcase
      end
   end

endmodule
